// File: rtl/apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : apb_master_arbiter
// Brief   : Shares one slave-side APB bus between several APB masters, holding
//           each grant for a full SETUP/ACCESS transfer (fixed or RR priority).
// Revision: 1.0 - initial release
// ============================================================================
module apb_master_arbiter #(
    parameter int NO_OF_MASTERS = 2,
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 32,
    parameter int PSEL_WIDTH    = 1,
    parameter int ARB_MODE      = 0
) (
    input  logic                                 I_PCLK,
    input  logic                                 I_PRESET,
    input  logic [NO_OF_MASTERS*PSEL_WIDTH-1:0]  I_M_PSEL,
    input  logic [NO_OF_MASTERS-1:0]             I_M_PENABLE,
    input  logic [NO_OF_MASTERS-1:0]             I_M_PWRITE,
    input  logic [NO_OF_MASTERS*ADDR_WIDTH-1:0]  I_M_PADDR,
    input  logic [NO_OF_MASTERS*DATA_WIDTH-1:0]  I_M_PWDATA,
    output logic [NO_OF_MASTERS-1:0]             O_M_PREADY,
    output logic [DATA_WIDTH-1:0]                O_M_PRDATA,
    output logic [NO_OF_MASTERS-1:0]             O_M_PSLVERR,
    output logic [PSEL_WIDTH-1:0]                O_PSEL,
    output logic                                 O_PENABLE,
    output logic                                 O_PWRITE,
    output logic [ADDR_WIDTH-1:0]                O_PADDR,
    output logic [DATA_WIDTH-1:0]                O_PWDATA,
    input  logic                                 I_PREADY,
    input  logic [DATA_WIDTH-1:0]                I_PRDATA,
    input  logic                                 I_PSLVERR,
    output logic [NO_OF_MASTERS-1:0]             O_GRANT
);

    localparam int         c_IDX_W  = $clog2(NO_OF_MASTERS);
    localparam logic [2:0] c_IDLE   = 3'b001;
    localparam logic [2:0] c_SETUP  = 3'b010;
    localparam logic [2:0] c_ACCESS = 3'b100;

    logic [2:0]               r_state;
    logic [2:0]               w_next;
    logic [NO_OF_MASTERS-1:0] w_req;
    logic [NO_OF_MASTERS-1:0] r_grant;
    logic [NO_OF_MASTERS-1:0] w_win_oh;
    logic [c_IDX_W-1:0]       r_last;
    logic [c_IDX_W-1:0]       w_fp_idx;
    logic [c_IDX_W-1:0]       w_rr_idx;
    logic [c_IDX_W-1:0]       w_cand;
    logic [c_IDX_W-1:0]       w_win_idx;
    logic                     w_any_req;
    logic [PSEL_WIDTH-1:0]    w_psel;
    logic                     w_pwrite;
    logic [ADDR_WIDTH-1:0]    w_paddr;
    logic [DATA_WIDTH-1:0]    w_pwdata;

    // Master PENABLE carries no information here; phases are regenerated.
    logic w_unused_penable;
    assign w_unused_penable = ^I_M_PENABLE;

    always_comb begin
        w_req = '0;
        for (int m = 0; m < NO_OF_MASTERS; m++) begin
            w_req[m] = |I_M_PSEL[m*PSEL_WIDTH +: PSEL_WIDTH];
        end
    end

    assign w_any_req = |w_req;

    // Descending scans so the last assignment is the highest-priority hit.
    always_comb begin
        w_fp_idx = '0;
        for (int m = NO_OF_MASTERS - 1; m >= 0; m--) begin
            if (w_req[m]) w_fp_idx = c_IDX_W'(m);
        end
    end

    always_comb begin
        w_rr_idx = '0;
        w_cand   = '0;
        for (int k = NO_OF_MASTERS; k >= 1; k--) begin
            w_cand = c_IDX_W'((int'(r_last) + k) % NO_OF_MASTERS);
            if (w_req[w_cand]) w_rr_idx = w_cand;
        end
    end

    assign w_win_idx = (ARB_MODE == 1) ? w_rr_idx : w_fp_idx;

    always_comb begin
        w_win_oh            = '0;
        w_win_oh[w_win_idx] = 1'b1;
    end

    // State register
    always_ff @(posedge I_PCLK or posedge I_PRESET) begin
        if (I_PRESET) r_state <= c_IDLE;
        else          r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE:   if (w_any_req) w_next = c_SETUP;
            c_SETUP:  w_next = c_ACCESS;
            c_ACCESS: if (I_PREADY) w_next = c_IDLE;
            default:  w_next = c_IDLE;
        endcase
    end

    // Grant is captured once per transfer and ignores request changes until completion.
    always_ff @(posedge I_PCLK or posedge I_PRESET) begin
        if (I_PRESET) begin
            r_grant <= '0;
            r_last  <= c_IDX_W'(NO_OF_MASTERS - 1);
        end else if (r_state == c_IDLE && w_any_req) begin
            r_grant <= w_win_oh;
            r_last  <= w_win_idx;
        end else if (r_state == c_ACCESS && I_PREADY) begin
            r_grant <= '0;
        end
    end

    always_comb begin
        w_psel   = '0;
        w_pwrite = 1'b0;
        w_paddr  = '0;
        w_pwdata = '0;
        for (int m = 0; m < NO_OF_MASTERS; m++) begin
            if (r_grant[m]) begin
                w_psel   |= I_M_PSEL[m*PSEL_WIDTH +: PSEL_WIDTH];
                w_pwrite |= I_M_PWRITE[m];
                w_paddr  |= I_M_PADDR[m*ADDR_WIDTH +: ADDR_WIDTH];
                w_pwdata |= I_M_PWDATA[m*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Output logic
    always_comb begin
        O_PSEL      = '0;
        O_PENABLE   = 1'b0;
        O_PWRITE    = 1'b0;
        O_PADDR     = '0;
        O_PWDATA    = '0;
        O_M_PREADY  = '0;
        O_M_PSLVERR = '0;
        if (r_state == c_SETUP || r_state == c_ACCESS) begin
            O_PSEL   = w_psel;
            O_PWRITE = w_pwrite;
            O_PADDR  = w_paddr;
            O_PWDATA = w_pwdata;
        end
        if (r_state == c_ACCESS) begin
            O_PENABLE = 1'b1;
            if (I_PREADY) begin
                O_M_PREADY  = r_grant;
                O_M_PSLVERR = r_grant & {NO_OF_MASTERS{I_PSLVERR}};
            end
        end
    end

    assign O_GRANT    = r_grant;
    assign O_M_PRDATA = I_PRDATA;

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : tb_apb_master_arbiter
// Brief   : Fixed-priority and round-robin arbiters driven side by side from one
//           stimulus stream and compared against a transfer-level model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_apb_master_arbiter;

    localparam int NM = 4;
    localparam int AW = 16;
    localparam int DW = 32;
    localparam int PW = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [NM*PW-1:0] m_psel;
    logic [NM-1:0]    m_pen;
    logic [NM-1:0]    m_pwrite;
    logic [NM*AW-1:0] m_paddr;
    logic [NM*DW-1:0] m_pwdata;
    logic            s_pready;
    logic [DW-1:0]   s_prdata;
    logic            s_pslverr;

    logic [NM-1:0] fp_rdy, fp_err, fp_gnt, rr_rdy, rr_err, rr_gnt;
    logic [DW-1:0] fp_rd, rr_rd, fp_pd, rr_pd;
    logic [PW-1:0] fp_psel, rr_psel;
    logic          fp_pen, rr_pen, fp_pw, rr_pw;
    logic [AW-1:0] fp_pa, rr_pa;

    always #5 clk = ~clk;

    apb_master_arbiter #(.NO_OF_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                         .PSEL_WIDTH(PW), .ARB_MODE(0)) u_fp (
        .I_PCLK(clk), .I_PRESET(rst),
        .I_M_PSEL(m_psel), .I_M_PENABLE(m_pen), .I_M_PWRITE(m_pwrite),
        .I_M_PADDR(m_paddr), .I_M_PWDATA(m_pwdata),
        .O_M_PREADY(fp_rdy), .O_M_PRDATA(fp_rd), .O_M_PSLVERR(fp_err),
        .O_PSEL(fp_psel), .O_PENABLE(fp_pen), .O_PWRITE(fp_pw),
        .O_PADDR(fp_pa), .O_PWDATA(fp_pd),
        .I_PREADY(s_pready), .I_PRDATA(s_prdata), .I_PSLVERR(s_pslverr),
        .O_GRANT(fp_gnt)
    );

    apb_master_arbiter #(.NO_OF_MASTERS(NM), .ADDR_WIDTH(AW), .DATA_WIDTH(DW),
                         .PSEL_WIDTH(PW), .ARB_MODE(1)) u_rr (
        .I_PCLK(clk), .I_PRESET(rst),
        .I_M_PSEL(m_psel), .I_M_PENABLE(m_pen), .I_M_PWRITE(m_pwrite),
        .I_M_PADDR(m_paddr), .I_M_PWDATA(m_pwdata),
        .O_M_PREADY(rr_rdy), .O_M_PRDATA(rr_rd), .O_M_PSLVERR(rr_err),
        .O_PSEL(rr_psel), .O_PENABLE(rr_pen), .O_PWRITE(rr_pw),
        .O_PADDR(rr_pa), .O_PWDATA(rr_pd),
        .I_PREADY(s_pready), .I_PRDATA(s_prdata), .I_PSLVERR(s_pslverr),
        .O_GRANT(rr_gnt)
    );

    int errors = 0;
    int checks = 0;

    // Transfer-level model: phase 0 idle, 1 setup, 2 access; grants as master indices.
    int ph, fp_g, rr_g, rr_last;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NM-1:0] reqv();
        logic [NM-1:0] r;
        for (int m = 0; m < NM; m++) r[m] = |m_psel[m*PW +: PW];
        return r;
    endfunction

    function automatic int fp_pick(input logic [NM-1:0] r);
        for (int i = 0; i < NM; i++) if (r[i]) return i;
        return -1;
    endfunction

    function automatic int rr_pick(input logic [NM-1:0] r, input int last);
        for (int k = 1; k <= NM; k++) if (r[(last + k) % NM]) return (last + k) % NM;
        return -1;
    endfunction

    task automatic model_reset();
        ph = 0; fp_g = -1; rr_g = -1; rr_last = NM - 1;
    endtask

    task automatic model_update();
        logic [NM-1:0] r;
        r = reqv();
        if (rst) model_reset();
        else if (ph == 0) begin
            if (r != '0) begin
                fp_g = fp_pick(r);
                rr_g = rr_pick(r, rr_last);
                rr_last = rr_g;
                ph = 1;
            end
        end else if (ph == 1) ph = 2;
        else if (s_pready) begin
            ph = 0; fp_g = -1; rr_g = -1;
        end
    endtask

    task automatic check_dut(input string p, input int g, input logic [PW-1:0] psel,
                             input logic pen, input logic pw, input logic [AW-1:0] pa,
                             input logic [DW-1:0] pd, input logic [NM-1:0] rdy,
                             input logic [NM-1:0] err, input logic [DW-1:0] rd,
                             input logic [NM-1:0] gnt);
        logic [PW-1:0] e_psel = '0;
        logic          e_pw = 1'b0;
        logic [AW-1:0] e_pa = '0;
        logic [DW-1:0] e_pd = '0;
        logic [NM-1:0] e_gnt = '0, e_rdy = '0, e_err = '0;
        if (ph != 0) begin
            e_psel = m_psel[g*PW +: PW];
            e_pw   = m_pwrite[g];
            e_pa   = m_paddr[g*AW +: AW];
            e_pd   = m_pwdata[g*DW +: DW];
            e_gnt  = NM'(1) << g;
            if (ph == 2 && s_pready) begin
                e_rdy = e_gnt;
                e_err = s_pslverr ? e_gnt : '0;
            end
        end
        chk({p, "_psel"}, 64'(psel), 64'(e_psel));
        chk({p, "_penable"}, 64'(pen), 64'(ph == 2));
        chk({p, "_pwrite"}, 64'(pw), 64'(e_pw));
        chk({p, "_paddr"}, 64'(pa), 64'(e_pa));
        chk({p, "_pwdata"}, 64'(pd), 64'(e_pd));
        chk({p, "_grant"}, 64'(gnt), 64'(e_gnt));
        chk({p, "_m_pready"}, 64'(rdy), 64'(e_rdy));
        chk({p, "_m_pslverr"}, 64'(err), 64'(e_err));
        chk({p, "_m_prdata"}, 64'(rd), 64'(s_prdata));
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge.
    task automatic cycle();
        @(negedge clk);
        check_dut("fp", fp_g, fp_psel, fp_pen, fp_pw, fp_pa, fp_pd, fp_rdy, fp_err, fp_rd, fp_gnt);
        check_dut("rr", rr_g, rr_psel, rr_pen, rr_pw, rr_pa, rr_pd, rr_rdy, rr_err, rr_rd, rr_gnt);
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_m(input int m, input logic [PW-1:0] ps, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        m_psel[m*PW +: PW]   = ps;
        m_pwrite[m]          = w;
        m_paddr[m*AW +: AW]  = a;
        m_pwdata[m*DW +: DW] = d;
    endtask

    initial begin
        int cnt_m0, cnt_m1, n;
        logic [NM-1:0] rr_seq [5];
        logic [NM-1:0] rr_exp [5];

        rst = 1'b1; m_psel = '0; m_pen = '0; m_pwrite = '0; m_paddr = '0; m_pwdata = '0;
        s_pready = 1'b0; s_prdata = '0; s_pslverr = 1'b0;
        model_reset();
        #1;
        chk("reset_grant", 64'(fp_gnt), 64'h0);
        chk("reset_psel", 64'(rr_psel), 64'h0);
        cycle(); cycle();
        rst = 1'b0;
        cycle();

        // Single request from master 1, slave ready immediately
        set_m(1, 2'b01, 1'b1, 16'h0040, 32'hDEADBEEF);
        s_pready = 1'b1;
        cycle();
        chk("t1_setup_grant", 64'(fp_gnt), 64'b0010);
        chk("t1_setup_penable", 64'(fp_pen), 64'h0);
        chk("t1_setup_paddr", 64'(fp_pa), 64'h0040);
        cycle();
        chk("t1_access_m_pready", 64'(fp_rdy), 64'b0010);
        chk("t1_access_pwdata", 64'(rr_pd), 64'hDEADBEEF);
        chk("t1_access_penable", 64'(rr_pen), 64'h1);
        cycle();
        set_m(1, 2'b00, 1'b0, 16'h0, 32'h0);
        cycle();

        // Read by master 0 with three wait states and an error response
        set_m(0, 2'b10, 1'b0, 16'h1234, 32'h0);
        s_pready = 1'b0; s_pslverr = 1'b1;
        cycle();
        cycle();
        for (int i = 0; i < 3; i++) begin
            chk("t4_wait_penable", 64'(fp_pen), 64'h1);
            chk("t4_wait_m_pready", 64'(fp_rdy), 64'h0);
            chk("t4_wait_m_pslverr", 64'(fp_err), 64'h0);
            cycle();
        end
        s_pready = 1'b1; s_prdata = 32'hCAFE0123;
        #1;
        chk("t4_done_penable", 64'(fp_pen), 64'h1);
        chk("t4_done_m_pready", 64'(fp_rdy), 64'b0001);
        chk("t4_done_m_pslverr", 64'(fp_err), 64'b0001);
        chk("t4_done_m_prdata", 64'(fp_rd), 64'hCAFE0123);
        cycle();
        s_pslverr = 1'b0;

        // Masters 0 and 1 requesting continuously
        set_m(0, 2'b01, 1'b1, 16'h0100, 32'h11111111);
        set_m(1, 2'b10, 1'b1, 16'h0200, 32'h22222222);
        cnt_m0 = 0; cnt_m1 = 0; n = 0;
        rr_exp = '{4'b0010, 4'b0001, 4'b0010, 4'b0001, 4'b0010};
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (fp_gnt[1]) cnt_m1++;
            if (fp_gnt == 4'b0001 && !fp_pen) cnt_m0++;
            if (rr_gnt != '0 && !rr_pen && n < 5) begin
                rr_seq[n] = rr_gnt;
                n++;
            end
        end
        chk("t2_fp_m1_grants", 64'(cnt_m1), 64'h0);
        chk("t2_fp_m0_grants", 64'(cnt_m0), 64'h5);
        chk("t6_rr_count", 64'(n), 64'h5);
        for (int i = 0; i < 5; i++) chk("t6_rr_seq", 64'(rr_seq[i]), 64'(rr_exp[i]));

        // Reset during ACCESS, then round-robin from master 0 with all four requesting
        set_m(2, 2'b11, 1'b0, 16'h0300, 32'h33333333);
        set_m(3, 2'b01, 1'b1, 16'h0400, 32'h44444444);
        cycle(); cycle();
        chk("t5_pre_penable", 64'(rr_pen), 64'h1);
        rst = 1'b1;
        model_reset();
        #1;
        chk("t5_rst_psel", 64'(rr_psel), 64'h0);
        chk("t5_rst_penable", 64'(rr_pen), 64'h0);
        chk("t5_rst_grant", 64'(rr_gnt), 64'h0);
        chk("t5_rst_m_pready", 64'(rr_rdy), 64'h0);
        chk("t5_rst_fp_penable", 64'(fp_pen), 64'h0);
        cycle();
        rst = 1'b0;
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        n = 0;
        for (int i = 0; i < 15; i++) begin
            cycle();
            if (rr_gnt != '0 && !rr_pen && n < 5) begin
                rr_seq[n] = rr_gnt;
                n++;
            end
        end
        chk("t3_rr_count", 64'(n), 64'h5);
        for (int i = 0; i < 5; i++) chk("t3_rr_seq", 64'(rr_seq[i]), 64'(rr_exp[i]));

        // Randomised traffic, slave responses and occasional asynchronous reset
        for (int i = 0; i < 400; i++) begin
            for (int m = 0; m < NM; m++) begin
                if ($urandom_range(0, 3) == 0)
                    set_m(m, PW'($urandom_range(0, 3)), 1'($urandom), AW'($urandom), $urandom);
            end
            m_pen     = NM'($urandom);
            s_pready  = 1'($urandom);
            s_prdata  = $urandom;
            s_pslverr = 1'($urandom);
            if ($urandom_range(0, 79) == 0) begin
                rst = 1'b1;
                model_reset();
            end else begin
                rst = 1'b0;
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
